serv_lsbuf2: RTL and testbench

Parametrised successor to the SERV load/store/shift buffer register. Supports datapath widths W = 1/2/4/8.
- Holds the 32-bit data word for stores and loads.
- Acts as the shift-amount down-counter for shift ops.
- Adds what the earlier block lacked: its own data-bus handshake FSM (cyc/ack), byte-select generation, and a sub-W residual shift output.
- Sits between the SERV state/decode logic, the ALU/rd path and the external data bus.

---
 rtl/serv_lsbuf_pkg.sv | 31 +++
 rtl/serv_lsbuf_fsm.sv | 86 ++++++++
 rtl/serv_lsbuf2.sv | 130 +++++++++++++
 tb/tb_serv_lsbuf2.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_lsbuf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : serv_lsbuf_pkg                                              |
// | Desc   : Shared types, size codes and byte-select helper for lsbuf2. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package serv_lsbuf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_LOAD_HOLD = 2'd2
    } lsbuf_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Unknown size codes fall back to a full-word enable.
    function automatic logic [3:0] sel_from(input logic [1:0] size, input logic [1:0] lsb);
        logic [3:0] sel;
        case (size)
            SZ_BYTE: sel = 4'b0001 << lsb;
            SZ_HALF: sel = 4'b0011 << lsb;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serv_lsbuf_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : serv_lsbuf_fsm                                              |
// | Desc   : Data-bus handshake FSM with registered cyc and byte enables.|
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module serv_lsbuf_fsm
    import serv_lsbuf_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_mem_op,
    input  logic       i_we,
    input  logic       i_ack,
    input  logic       i_en,
    input  logic       i_cnt_done,
    input  logic [1:0] i_size,
    input  logic [1:0] i_lsb,
    output logic       o_busy,
    output logic       o_cyc,
    output logic [3:0] o_sel,
    output logic       o_capture,
    output logic       o_hold_shift
);

    lsbuf_state_t r_state;
    lsbuf_state_t w_next;
    logic         r_cyc;
    logic [3:0]   r_sel;
    logic         r_we;
    logic         w_launch;

    assign w_launch = (r_state == ST_IDLE) & i_start & i_mem_op;

    always_comb begin
        w_next       = r_state;
        o_capture    = 1'b0;
        o_hold_shift = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) w_next = ST_REQ;
            end
            ST_REQ: begin
                if (i_ack) begin
                    if (r_we) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_next    = ST_LOAD_HOLD;
                        o_capture = 1'b1;
                    end
                end
            end
            ST_LOAD_HOLD: begin
                if (i_en) begin
                    o_hold_shift = 1'b1;
                    if (i_cnt_done) w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Direction is latched at launch so a late change of i_we cannot redirect an ack.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cyc   <= 1'b0;
            r_sel   <= 4'b0000;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cyc   <= (w_next == ST_REQ);
            if (w_launch) begin
                r_sel <= sel_from(i_size, i_lsb);
                r_we  <= i_we;
            end
        end
    end

    assign o_busy = (r_state != ST_IDLE);
    assign o_cyc  = r_cyc;
    assign o_sel  = r_sel;

endmodule
`default_nettype wire

// File: rtl/serv_lsbuf2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : serv_lsbuf2                                                 |
// | Desc   : Load/store/shift buffer with bus FSM, W = 1/2/4/8.          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module serv_lsbuf2
    import serv_lsbuf_pkg::*;
#(
    parameter int W = 1,
    localparam int B = W - 1,
    localparam int L = (W > 1) ? $clog2(W) : 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_init,
    input  logic         i_cnt_done,
    input  logic         i_sh_right,
    input  logic [1:0]   i_lsb,
    input  logic [1:0]   i_bytecnt,
    input  logic [1:0]   i_size,
    input  logic         i_op_b_sel,
    input  logic         i_shift_op,
    input  logic         i_mem_op,
    input  logic         i_we,
    input  logic         i_dbus_start,
    input  logic [B:0]   i_rs2,
    input  logic [B:0]   i_imm,
    output logic [B:0]   o_op_b,
    output logic [B:0]   o_q,
    output logic         o_sh_done,
    output logic [L-1:0] o_sh_frac,
    output logic         o_busy,
    output logic         o_dbus_cyc,
    output logic [3:0]   o_dbus_sel,
    output logic [31:0]  o_dbus_dat,
    input  logic         i_dbus_ack,
    input  logic [31:0]  i_dbus_rdt
);

    if (W != 1 && W != 2 && W != 4 && W != 8) begin : g_bad_width
        $error("serv_lsbuf2: W must be 1, 2, 4 or 8");
    end

    logic [31:0]  r_dat;
    logic [31:0]  w_dat_next;
    logic         r_sh_done;
    logic [L-1:0] r_sh_frac;
    logic [L-1:0] w_frac_src;
    logic [2:0]   w_byte_sum;
    logic         w_store_fill;
    logic         w_shift_fill;
    logic         w_cnt_en;
    logic [5:0]   w_cnt_next;
    logic         w_capture;
    logic         w_hold_shift;

    serv_lsbuf_fsm u_fsm (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_dbus_start),
        .i_mem_op     (i_mem_op),
        .i_we         (i_we),
        .i_ack        (i_dbus_ack),
        .i_en         (i_en),
        .i_cnt_done   (i_cnt_done),
        .i_size       (i_size),
        .i_lsb        (i_lsb),
        .o_busy       (o_busy),
        .o_cyc        (o_dbus_cyc),
        .o_sel        (o_dbus_sel),
        .o_capture    (w_capture),
        .o_hold_shift (w_hold_shift)
    );

    assign o_op_b = i_op_b_sel ? i_rs2 : i_imm;

    // Store bytes past the top of the word are dropped so rs2 lands at i_lsb.
    assign w_byte_sum   = {1'b0, i_lsb} + {1'b0, i_bytecnt};
    assign w_store_fill = i_mem_op & i_we & i_init & i_en & (w_byte_sum < 3'd4);
    assign w_shift_fill = i_shift_op & i_init & i_en & (i_bytecnt == 2'd0);
    assign w_cnt_en     = i_shift_op & (!i_init | (i_cnt_done & i_sh_right)) & i_en & !w_capture;
    assign w_cnt_next   = r_dat[5:0] - 6'(W);

    if (W == 1) begin : g_frac_w1
        assign w_frac_src = '0;
    end else begin : g_frac_wn
        assign w_frac_src = r_dat[L-1:0];
    end

    always_comb begin
        w_dat_next = r_dat;
        if (w_capture) begin
            w_dat_next = i_dbus_rdt;
        end else if (w_cnt_en) begin
            w_dat_next = {r_dat[31:6], w_cnt_next};
        end else if (w_hold_shift) begin
            w_dat_next = r_dat >> W;
        end else if (w_store_fill | w_shift_fill) begin
            w_dat_next = {o_op_b, r_dat[31:W]};
            if (w_shift_fill & i_cnt_done) w_dat_next[5] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dat     <= 32'd0;
            r_sh_done <= 1'b0;
            r_sh_frac <= '0;
        end else begin
            r_dat <= w_dat_next;
            if (w_cnt_en) begin
                r_sh_done <= w_cnt_next[5];
                // Residue is taken from the pre-borrow count on the first borrow only.
                if (w_cnt_next[5] & !r_sh_done) r_sh_frac <= w_frac_src;
            end else if (w_shift_fill) begin
                r_sh_done <= 1'b0;
                r_sh_frac <= '0;
            end
        end
    end

    assign o_sh_done  = r_sh_done;
    assign o_sh_frac  = r_sh_frac;
    assign o_dbus_dat = r_dat;
    assign o_q        = r_dat[{i_lsb, 3'b000} +: W];

endmodule
`default_nettype wire

// File: tb/tb_serv_lsbuf2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_serv_lsbuf2                                              |
// | Desc   : Directed self-checking bench, one DUT per legal width.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_serv_lsbuf2;

    logic        clk = 1'b0;
    logic        rst_n, en, init, cnt_done, sh_right, op_b_sel, shift_op, mem_op, we;
    logic        dbus_start, dbus_ack;
    logic [1:0]  lsb, bytecnt, size;
    logic [31:0] dbus_rdt;

    logic [0:0] rs2_1, imm_1, op_b_1, q_1, frac_1;
    logic [1:0] rs2_2, imm_2, op_b_2, q_2;
    logic [0:0] frac_2;
    logic [3:0] rs2_4, imm_4, op_b_4, q_4;
    logic [1:0] frac_4;
    logic [7:0] rs2_8, imm_8, op_b_8, q_8;
    logic [2:0] frac_8;
    logic       done_1, done_2, done_4, done_8;
    logic       busy_1, busy_2, busy_4, busy_8;
    logic       cyc_1, cyc_2, cyc_4, cyc_8;
    logic [3:0] sel_1, sel_2, sel_4, sel_8;
    logic [31:0] dat_1, dat_2, dat_4, dat_8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serv_lsbuf2 #(.W(1)) u_dut_1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_init(init), .i_cnt_done(cnt_done),
        .i_sh_right(sh_right), .i_lsb(lsb), .i_bytecnt(bytecnt), .i_size(size),
        .i_op_b_sel(op_b_sel), .i_shift_op(shift_op), .i_mem_op(mem_op), .i_we(we),
        .i_dbus_start(dbus_start), .i_rs2(rs2_1), .i_imm(imm_1), .o_op_b(op_b_1),
        .o_q(q_1), .o_sh_done(done_1), .o_sh_frac(frac_1), .o_busy(busy_1),
        .o_dbus_cyc(cyc_1), .o_dbus_sel(sel_1), .o_dbus_dat(dat_1),
        .i_dbus_ack(dbus_ack), .i_dbus_rdt(dbus_rdt));

    serv_lsbuf2 #(.W(2)) u_dut_2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_init(init), .i_cnt_done(cnt_done),
        .i_sh_right(sh_right), .i_lsb(lsb), .i_bytecnt(bytecnt), .i_size(size),
        .i_op_b_sel(op_b_sel), .i_shift_op(shift_op), .i_mem_op(mem_op), .i_we(we),
        .i_dbus_start(dbus_start), .i_rs2(rs2_2), .i_imm(imm_2), .o_op_b(op_b_2),
        .o_q(q_2), .o_sh_done(done_2), .o_sh_frac(frac_2), .o_busy(busy_2),
        .o_dbus_cyc(cyc_2), .o_dbus_sel(sel_2), .o_dbus_dat(dat_2),
        .i_dbus_ack(dbus_ack), .i_dbus_rdt(dbus_rdt));

    serv_lsbuf2 #(.W(4)) u_dut_4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_init(init), .i_cnt_done(cnt_done),
        .i_sh_right(sh_right), .i_lsb(lsb), .i_bytecnt(bytecnt), .i_size(size),
        .i_op_b_sel(op_b_sel), .i_shift_op(shift_op), .i_mem_op(mem_op), .i_we(we),
        .i_dbus_start(dbus_start), .i_rs2(rs2_4), .i_imm(imm_4), .o_op_b(op_b_4),
        .o_q(q_4), .o_sh_done(done_4), .o_sh_frac(frac_4), .o_busy(busy_4),
        .o_dbus_cyc(cyc_4), .o_dbus_sel(sel_4), .o_dbus_dat(dat_4),
        .i_dbus_ack(dbus_ack), .i_dbus_rdt(dbus_rdt));

    serv_lsbuf2 #(.W(8)) u_dut_8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_init(init), .i_cnt_done(cnt_done),
        .i_sh_right(sh_right), .i_lsb(lsb), .i_bytecnt(bytecnt), .i_size(size),
        .i_op_b_sel(op_b_sel), .i_shift_op(shift_op), .i_mem_op(mem_op), .i_we(we),
        .i_dbus_start(dbus_start), .i_rs2(rs2_8), .i_imm(imm_8), .o_op_b(op_b_8),
        .o_q(q_8), .o_sh_done(done_8), .o_sh_frac(frac_8), .o_busy(busy_8),
        .o_dbus_cyc(cyc_8), .o_dbus_sel(sel_8), .o_dbus_dat(dat_8),
        .i_dbus_ack(dbus_ack), .i_dbus_rdt(dbus_rdt));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive cycle c's slice of word on the selected operand, its inverse on the other.
    task automatic drive_slices(input logic [31:0] word, input int c);
        logic [31:0] s1, s2, s4, s8;
        s1 = word >> c;
        s2 = word >> (2 * c);
        s4 = word >> (4 * c);
        s8 = word >> (8 * c);
        rs2_1 = op_b_sel ? s1[0:0] : ~s1[0:0];
        imm_1 = op_b_sel ? ~s1[0:0] : s1[0:0];
        rs2_2 = op_b_sel ? s2[1:0] : ~s2[1:0];
        imm_2 = op_b_sel ? ~s2[1:0] : s2[1:0];
        rs2_4 = op_b_sel ? s4[3:0] : ~s4[3:0];
        imm_4 = op_b_sel ? ~s4[3:0] : s4[3:0];
        rs2_8 = op_b_sel ? s8[7:0] : ~s8[7:0];
        imm_8 = op_b_sel ? ~s8[7:0] : s8[7:0];
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 0; init = 0; cnt_done = 0; sh_right = 0; op_b_sel = 1;
        shift_op = 0; mem_op = 0; we = 0; dbus_start = 0; dbus_ack = 0;
        lsb = 0; bytecnt = 0; size = 0; dbus_rdt = 32'd0;
        rs2_1 = 0; imm_1 = 0; rs2_2 = 0; imm_2 = 0; rs2_8 = 0; imm_8 = 0;
        rs2_4 = 4'h9; imm_4 = 4'h6;
        tick(); tick();

        // Reset state and the operand-B mux
        chk("rst_cyc", 32'(cyc_1), 32'd0);
        chk("rst_busy", 32'(busy_1), 32'd0);
        chk("rst_sh_done", 32'(done_8), 32'd0);
        chk("rst_sel", 32'(sel_1), 32'd0);
        chk("rst_frac", 32'(frac_8), 32'd0);
        chk("rst_dat", dat_4, 32'd0);
        chk("op_b_rs2", 32'(op_b_4), 32'h9);
        op_b_sel = 0; #1;
        chk("op_b_imm", 32'(op_b_4), 32'h6);
        op_b_sel = 1;
        rst_n = 1'b1;
        tick();

        // W=1 store word 0xDEADBEEF at lsb 0
        mem_op = 1; we = 1; init = 1; en = 1; size = 2'd2; lsb = 2'd0;
        for (int c = 0; c < 32; c++) begin
            drive_slices(32'hDEADBEEF, c);
            bytecnt  = 2'(c / 8);
            cnt_done = (c == 31);
            tick();
        end
        init = 0; en = 0; cnt_done = 0;
        chk("w1_store_dat", dat_1, 32'hDEADBEEF);
        dbus_start = 1;
        tick();
        dbus_start = 0;
        chk("w1_sel_word", 32'(sel_1), 32'hF);
        chk("w1_cyc_0", 32'(cyc_1), 32'd1);
        tick();
        chk("w1_cyc_1", 32'(cyc_1), 32'd1);
        tick();
        chk("w1_cyc_2", 32'(cyc_1), 32'd1);
        dbus_ack = 1;
        tick();
        dbus_ack = 0;
        chk("w1_cyc_drop", 32'(cyc_1), 32'd0);
        chk("w1_idle", 32'(busy_1), 32'd0);
        chk("w1_dat_kept", dat_1, 32'hDEADBEEF);

        // W=4 store byte 0xA5 at lsb 3
        init = 1; en = 1; size = 2'd0; lsb = 2'd3;
        for (int c = 0; c < 8; c++) begin
            drive_slices(32'h000000A5, c);
            bytecnt  = 2'(c / 2);
            cnt_done = (c == 7);
            tick();
        end
        init = 0; en = 0; cnt_done = 0;
        chk("w4_store_byte3", 32'(dat_4[31:24]), 32'hA5);
        dbus_start = 1;
        tick();
        dbus_start = 0;
        chk("w4_sel_byte3", 32'(sel_4), 32'h8);
        dbus_ack = 1;
        tick();
        dbus_ack = 0;
        chk("w4_cyc_drop", 32'(cyc_4), 32'd0);

        // W=2 load half at lsb 2
        we = 0; size = 2'd1; lsb = 2'd2; bytecnt = 0;
        dbus_start = 1;
        tick();
        dbus_start = 0;
        chk("w2_sel_half2", 32'(sel_2), 32'hC);
        chk("w2_busy_req", 32'(busy_2), 32'd1);
        dbus_start = 1;
        dbus_rdt = 32'h1234ABCD; dbus_ack = 1;
        tick();
        dbus_start = 0; dbus_ack = 0; dbus_rdt = 32'd0;
        chk("w2_capture", dat_2, 32'h1234ABCD);
        chk("w2_q0", 32'(q_2), 32'h0);
        chk("w2_hold", 32'(busy_2), 32'd1);
        en = 1;
        tick();
        chk("w2_q1", 32'(q_2), 32'h1);
        tick();
        chk("w2_q2", 32'(q_2), 32'h3);
        tick();
        chk("w2_q3", 32'(q_2), 32'h0);
        cnt_done = 1;
        tick();
        en = 0; cnt_done = 0; mem_op = 0;
        chk("w2_q4", 32'(q_2), 32'h2);
        chk("w2_exit_idle", 32'(busy_2), 32'd0);
        tick();
        chk("w2_stay_idle", 32'(busy_2), 32'd0);

        // W=8 shift amount 13 via imm
        op_b_sel = 0; shift_op = 1; init = 1; en = 1; sh_right = 0; bytecnt = 0; lsb = 0;
        for (int c = 0; c < 4; c++) begin
            drive_slices(32'd13, c);
            cnt_done = (c == 3);
            tick();
        end
        init = 0; cnt_done = 0;
        chk("w8_shamt", dat_8, 32'd13);
        chk("w8_done_clr", 32'(done_8), 32'd0);
        tick();
        chk("w8_cnt1_val", 32'(dat_8[5:0]), 32'd5);
        chk("w8_cnt1_done", 32'(done_8), 32'd0);
        tick();
        chk("w8_cnt2_done", 32'(done_8), 32'd1);
        chk("w8_frac", 32'(frac_8), 32'h5);

        // W=1 shift amount 0
        init = 1;
        for (int c = 0; c < 32; c++) begin
            drive_slices(32'd0, c);
            cnt_done = (c == 31);
            tick();
        end
        init = 0; cnt_done = 0;
        chk("w1_sh0_done_clr", 32'(done_1), 32'd0);
        tick();
        chk("w1_sh0_done", 32'(done_1), 32'd1);
        chk("w1_sh0_frac", 32'(frac_1), 32'd0);

        // W=1 shift amount 31
        init = 1;
        for (int c = 0; c < 32; c++) begin
            drive_slices(32'd31, c);
            cnt_done = (c == 31);
            tick();
        end
        init = 0; cnt_done = 0;
        chk("w1_sh31_val", dat_1, 32'd31);
        for (int c = 0; c < 31; c++) tick();
        chk("w1_sh31_not_yet", 32'(done_1), 32'd0);
        tick();
        chk("w1_sh31_done", 32'(done_1), 32'd1);
        en = 0; shift_op = 0; op_b_sel = 1;

        // Reset in the middle of a load request, then a stale ack
        mem_op = 1; we = 0; size = 2'd2; lsb = 0;
        dbus_start = 1;
        tick();
        dbus_start = 0;
        chk("mid_cyc_before", 32'(cyc_1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_cyc_async", 32'(cyc_1), 32'd0);
        chk("mid_busy_async", 32'(busy_1), 32'd0);
        tick();
        rst_n = 1'b1;
        dbus_ack = 1; dbus_rdt = 32'hCAFEF00D;
        tick();
        dbus_ack = 0; dbus_rdt = 32'd0; mem_op = 0;
        chk("stale_ack_dat", dat_1, 32'd0);
        chk("stale_ack_idle", 32'(busy_1), 32'd0);
        chk("stale_ack_cyc", 32'(cyc_1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
